// File: rtl/md_issue_ctrl_if.sv
// md_issue_ctrl_if: launch/write bus between the issue controller and the multiply/divide unit
interface md_issue_ctrl_if #(parameter int W = 32);
  logic         md_start;
  logic [1:0]   md_sel;
  logic         md_w;
  logic         md_wsel;
  logic [W-1:0] md_d1;
  logic [W-1:0] md_d2;
  logic         md_busy;
  logic [W-1:0] md_hi;
  logic [W-1:0] md_lo;
  modport master (output md_start, md_sel, md_w, md_wsel, md_d1, md_d2, input md_busy, md_hi, md_lo);
  modport slave (input md_start, md_sel, md_w, md_wsel, md_d1, md_d2, output md_busy, md_hi, md_lo);
endinterface

// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: E-stage issue, hazard stall and HI/LO readback for the multiply/divide unit
module md_issue_ctrl #(
  parameter int ISSUE_TIMEOUT = 2,
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         op_valid,
  input  logic [2:0]   op_code,
  input  logic [W-1:0] rs_data,
  input  logic [W-1:0] rt_data,
  input  logic         flush,
  md_issue_ctrl_if.master md,
  output logic         stall,
  output logic [W-1:0] rd_data,
  output logic         rd_valid,
  output logic         div0,
  output logic         err
);
  localparam int CW = $clog2(ISSUE_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, RUN, WRITE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic err_nx, accept, is_md, is_mt, is_mf, dz, go_md, go_mt;
  assign is_md = !op_code[2];
  assign is_mt = op_code[2:1] == 2'b10;
  assign is_mf = &op_code[2:1];
  assign dz = op_code[1] && rt_data == '0;
  // busy seen in IDLE counts as an op in flight, so it stalls like any non-IDLE state
  assign stall = rst && op_valid && (state != IDLE || md.md_busy);
  assign accept = rst && op_valid && !flush && !stall;
  assign go_md = accept && is_md && !dz;
  assign go_mt = accept && is_mt;
  assign rd_valid = accept && is_mf;
  assign rd_data = rd_valid ? (op_code[0] ? md.md_lo : md.md_hi) : '0;
  // next state, issue timeout counter and sticky error
  always_comb begin
    state_nx = state;
    cnt_nx = '0;
    err_nx = err;
    case (state)
      IDLE: state_nx = md.md_busy ? RUN : go_md ? ISSUE : go_mt ? WRITE : IDLE;
      ISSUE: begin
        if (md.md_busy) state_nx = RUN;
        else if (cnt == CW'(ISSUE_TIMEOUT - 1)) begin
          state_nx = IDLE;
          err_nx = 1'b1;
        end else cnt_nx = cnt + 1'b1;
      end
      RUN: state_nx = md.md_busy ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      err <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      err <= err_nx;
    end
  end
  // registered launch pulses and operands; operands hold until the next accept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      md.md_start <= 1'b0;
      md.md_w <= 1'b0;
      md.md_sel <= '0;
      md.md_wsel <= 1'b0;
      md.md_d1 <= '0;
      md.md_d2 <= '0;
      div0 <= 1'b0;
    end else begin
      md.md_start <= go_md;
      md.md_w <= go_mt;
      div0 <= accept && is_md && dz;
      if (go_md) begin
        md.md_sel <= op_code[1:0];
        md.md_d1 <= rs_data;
        md.md_d2 <= rt_data;
      end
      if (go_mt) begin
        md.md_wsel <= !op_code[0];
        md.md_d1 <= rs_data;
      end
    end
  end
endmodule

// File: tb/tb_md_issue_ctrl.sv
// tb_md_issue_ctrl: directed checks of md_issue_ctrl against a small behavioural md unit
module tb_md_issue_ctrl;
  logic clk, rst, op_valid, flush, stall, rd_valid, div0, err;
  logic [2:0] op_code;
  logic [31:0] rs_data, rt_data, rd_data;
  int errs = 0, checks = 0, lat = 3;
  logic mute = 1'b0;
  logic busy, mhi_p, unused;
  logic [31:0] hi, lo, p_hi, p_lo;
  int rem;
  md_issue_ctrl_if #(.W(32)) mif();
  md_issue_ctrl #(.ISSUE_TIMEOUT(2), .W(32)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code), .rs_data(rs_data),
    .rt_data(rt_data), .flush(flush), .md(mif), .stall(stall), .rd_data(rd_data),
    .rd_valid(rd_valid), .div0(div0), .err(err)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  assign mif.md_busy = busy;
  assign mif.md_hi = hi;
  assign mif.md_lo = lo;
  // md unit: busy rises the cycle after start and stays high lat cycles; mute models a dead unit
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= 0; rem <= 0; hi <= 0; lo <= 0; p_hi <= 0; p_lo <= 0;
    end else begin
      if (mif.md_start && !mute) begin
        busy <= 1;
        rem <= lat;
        case (mif.md_sel)
          2'd0: {p_hi, p_lo} <= $signed({{32{mif.md_d1[31]}}, mif.md_d1}) * $signed({{32{mif.md_d2[31]}}, mif.md_d2});
          2'd1: {p_hi, p_lo} <= {32'b0, mif.md_d1} * {32'b0, mif.md_d2};
          2'd2: begin p_hi <= $signed(mif.md_d1) % $signed(mif.md_d2); p_lo <= $signed(mif.md_d1) / $signed(mif.md_d2); end
          default: begin p_hi <= mif.md_d1 % mif.md_d2; p_lo <= mif.md_d1 / mif.md_d2; end
        endcase
      end else if (busy) begin
        if (rem == 1) begin busy <= 0; hi <= p_hi; lo <= p_lo; end
        rem <= rem - 1;
      end
      if (mif.md_w) begin
        if (mif.md_wsel) hi <= mif.md_d1;
        else lo <= mif.md_d1;
      end
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic op(input logic v, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    op_valid = v; op_code = c; rs_data = a; rt_data = b;
    #1;
  endtask
  initial begin
    int n;
    rst = 0; flush = 0;
    op(0, 0, 0, 0);
    #12;
    chk("rst_start", mif.md_start, 0);
    chk("rst_err", err, 0);
    chk("rst_state", dut.state, 0);
    rst = 1;
    tick;
    // MULT then back-to-back MFLO
    op(1, 3'd0, 32'hFFFFFFFE, 32'd3);
    chk("mult_nostall", stall, 0);
    tick;
    chk("mult_start", mif.md_start, 1);
    chk("mult_sel", mif.md_sel, 0);
    chk("mult_d1", mif.md_d1, 32'hFFFFFFFE);
    chk("mult_d2", mif.md_d2, 32'd3);
    chk("mult_issue", dut.state, 1);
    op(1, 3'd7, 0, 0);
    chk("mflo_stall", stall, 1);
    chk("mflo_rdv_stalled", rd_valid, 0);
    tick;
    chk("start_one_cycle", mif.md_start, 0);
    tick;
    chk("mult_run", dut.state, 2);
    for (int i = 0; i < 20 && stall; i++) tick;
    chk("mflo_unstall", stall, 0);
    chk("mflo_rdv", rd_valid, 1);
    chk("mflo_data", rd_data, 32'hFFFFFFFA);
    // DIVU with long busy, MFHI waits the whole window
    lat = 11;
    op(1, 3'd3, 32'd100, 32'd7);
    tick;
    chk("divu_sel", mif.md_sel, 3);
    op(1, 3'd6, 0, 0);
    n = 0;
    for (int i = 0; i < 40 && stall; i++) begin n++; tick; end
    chk("divu_stall_cycles", n, 13);
    chk("mfhi_divu", rd_data, 32'd2);
    op(1, 3'd7, 0, 0);
    chk("mflo_divu", rd_data, 32'd14);
    tick;
    // MTHI then MFHI
    op(1, 3'd4, 32'h12345678, 0);
    tick;
    chk("mthi_w", mif.md_w, 1);
    chk("mthi_wsel", mif.md_wsel, 1);
    chk("mthi_d1", mif.md_d1, 32'h12345678);
    chk("mthi_nostart", mif.md_start, 0);
    op(1, 3'd6, 0, 0);
    chk("mfhi_write_stall", stall, 1);
    tick;
    chk("mfhi_after_stall", stall, 0);
    chk("mfhi_data", rd_data, 32'h12345678);
    chk("mthi_w_pulse", mif.md_w, 0);
    // DIV by zero
    op(1, 3'd2, 32'd5, 32'd0);
    chk("div0_nostall", stall, 0);
    tick;
    chk("div0_nostart", mif.md_start, 0);
    chk("div0_pulse", div0, 1);
    chk("div0_idle", dut.state, 0);
    op(1, 3'd7, 0, 0);
    chk("div0_prior_lo", rd_data, 32'd14);
    tick;
    chk("div0_once", div0, 0);
    // issue timeout
    lat = 3; mute = 1;
    op(1, 3'd0, 32'd2, 32'd3);
    tick;
    chk("tmo_start", mif.md_start, 1);
    op(0, 0, 0, 0);
    tick;
    chk("tmo_err_early", err, 0);
    tick;
    chk("tmo_err", err, 1);
    chk("tmo_idle", dut.state, 0);
    mute = 0;
    op(1, 3'd0, 32'd4, 32'd5);
    chk("tmo_new_nostall", stall, 0);
    tick;
    chk("tmo_new_start", mif.md_start, 1);
    chk("tmo_new_d1", mif.md_d1, 32'd4);
    op(0, 0, 0, 0);
    for (int i = 0; i < 20 && dut.state != 0; i++) tick;
    op(1, 3'd7, 0, 0);
    chk("tmo_new_lo", rd_data, 32'd20);
    chk("err_sticky", err, 1);
    // reset during RUN
    lat = 8;
    op(1, 3'd1, 32'd3, 32'd4);
    tick; tick; tick;
    chk("rst_run", dut.state, 2);
    op(1, 3'd7, 0, 0);
    chk("rst_run_stall", stall, 1);
    rst = 0;
    #1;
    chk("rst_async_stall", stall, 0);
    chk("rst_async_rdv", rd_valid, 0);
    chk("rst_async_rd", rd_data, 0);
    chk("rst_async_d1", mif.md_d1, 0);
    chk("rst_async_sel", mif.md_sel, 0);
    chk("rst_async_err", err, 0);
    chk("rst_async_state", dut.state, 0);
    rst = 1;
    tick;
    // flush blocks acceptance
    flush = 1;
    op(1, 3'd0, 32'd9, 32'd9);
    tick;
    chk("flush_nostart", mif.md_start, 0);
    chk("flush_idle", dut.state, 0);
    op(1, 3'd5, 32'd9, 0);
    tick;
    chk("flush_now", mif.md_w, 0);
    flush = 0;
    op(0, 0, 0, 0);
    tick;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
